// File: rtl/mem_access_unit.sv
// Memory-port responder: sized loads with lane extract/extend, sub-word stores via read-modify-write.
// Optional define MEM_ALIGN_CHK_EN: reject misaligned halfword/word requests with err instead of forcing alignment.
module mem_access_unit #(
  parameter int MEM_LAT = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        we,
  input  logic [1:0]  size,
  input  logic        sign_ext,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic        done,
  output logic [31:0] rdata,
  output logic        err,
  output logic [31:0] MemAddr,
  output logic        MemWr,
  output logic [31:0] MemDataIn,
  input  logic [31:0] MemDataOut
);

  localparam int NUM_LANES = 4;

  typedef enum logic [1:0] {IDLE, RD, WR, DONE} state_t;

  state_t      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic        we_q, we_d;
  logic [1:0]  size_q, size_d;
  logic        sext_q, sext_d;
  logic [1:0]  lo_q, lo_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic        mem_wr_q, mem_wr_d;
  logic [31:0] mem_din_q, mem_din_d;
  logic        done_q, done_d;

  logic        misalign;
  logic        req_word;
  logic [NUM_LANES-1:0] be;
  logic [31:0] wrep, merged, shb, load_val;
  logic [15:0] half_v;

  assign req_word = (size == 2'b00) || (size == 2'b11);

`ifdef MEM_ALIGN_CHK_EN
  assign misalign = ((size == 2'b01) && addr[0]) || (req_word && (addr[1:0] != 2'b00));
`else
  assign misalign = 1'b0;
`endif

  // Lane enables and store data replicated across lanes so the merge is a per-byte select.
  always_comb begin
    be   = 4'b1111;
    wrep = wdata_q;
    if (size_q == 2'b10) begin
      be   = 4'b0001 << lo_q;
      wrep = {4{wdata_q[7:0]}};
    end else if (size_q == 2'b01) begin
      be   = lo_q[1] ? 4'b1100 : 4'b0011;
      wrep = {2{wdata_q[15:0]}};
    end
  end

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    assign merged[8*i +: 8] = be[i] ? wrep[8*i +: 8] : MemDataOut[8*i +: 8];
  end

  assign shb    = MemDataOut >> {lo_q, 3'b000};
  assign half_v = lo_q[1] ? MemDataOut[31:16] : MemDataOut[15:0];

  always_comb begin
    load_val = MemDataOut;
    if (size_q == 2'b10)
      load_val = {{24{sext_q & shb[7]}}, shb[7:0]};
    else if (size_q == 2'b01)
      load_val = {{16{sext_q & half_v[15]}}, half_v};
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    we_d       = we_q;
    size_d     = size_q;
    sext_d     = sext_q;
    lo_d       = lo_q;
    wdata_d    = wdata_q;
    rdata_d    = rdata_q;
    err_d      = err_q;
    mem_addr_d = mem_addr_q;
    mem_din_d  = mem_din_q;
    mem_wr_d   = 1'b0;
    done_d     = 1'b0;
    case (state_q)
      IDLE: if (req) begin
        we_d       = we;
        size_d     = size;
        sext_d     = sign_ext;
        lo_d       = addr[1:0];
        wdata_d    = wdata;
        mem_addr_d = {addr[31:2], 2'b00};
        cnt_d      = 3'd0;
        err_d      = misalign;
        if (misalign) begin
          state_d = DONE;
          done_d  = 1'b1;
        end else if (we && req_word) begin
          state_d   = WR;
          mem_wr_d  = 1'b1;
          mem_din_d = wdata;
        end else begin
          state_d = RD;
        end
      end
      RD: begin
        if (cnt_q == 3'(MEM_LAT)) begin
          if (we_q) begin
            state_d   = WR;
            mem_wr_d  = 1'b1;
            mem_din_d = merged;
          end else begin
            state_d = DONE;
            done_d  = 1'b1;
            rdata_d = load_val;
          end
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end
      WR: begin
        state_d = DONE;
        done_d  = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= 3'd0;
      we_q       <= 1'b0;
      size_q     <= 2'b00;
      sext_q     <= 1'b0;
      lo_q       <= 2'b00;
      wdata_q    <= 32'd0;
      rdata_q    <= 32'd0;
      err_q      <= 1'b0;
      mem_addr_q <= 32'd0;
      mem_wr_q   <= 1'b0;
      mem_din_q  <= 32'd0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      we_q       <= we_d;
      size_q     <= size_d;
      sext_q     <= sext_d;
      lo_q       <= lo_d;
      wdata_q    <= wdata_d;
      rdata_q    <= rdata_d;
      err_q      <= err_d;
      mem_addr_q <= mem_addr_d;
      mem_wr_q   <= mem_wr_d;
      mem_din_q  <= mem_din_d;
      done_q     <= done_d;
    end
  end

  assign busy      = (state_q != IDLE);
  assign done      = done_q;
  assign rdata     = rdata_q;
  assign err       = err_q;
  assign MemAddr   = mem_addr_q;
  assign MemWr     = mem_wr_q;
  assign MemDataIn = mem_din_q;

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Memory-side responder for the multicycle datapath's memory port: accepts a load or store request, driven by the address-source mux, and runs the transaction against the single-port, word-wide data memory. It handles byte/halfword/word sizes, including read-modify-write for sub-word stores and lane extraction with sign/zero extension for loads. It sits between the control unit/datapath and the memory block, and replaces direct MemWr/MemData wiring.

## Interface

Parameters:
- MEM_LAT, 1: memory read latency in cycles, counted from the edge the memory samples the address to valid read data; legal range 1–4.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- req  in  1  request strobe; sampled only in IDLE.
- we  in  1  1 = store, 0 = load; sampled with req.
- size  in  2  00 word, 01 halfword, 10 byte; 11 treated as word.
- sign_ext  in  1  load extension: 1 sign, 0 zero; ignored for word and stores.
- addr  in  32  byte address from the address-source mux.
- wdata  in  32  store data; low byte or halfword is used for sub-word stores.
- busy  out  1  high whenever state ≠ IDLE.
- done  out  1  one-cycle completion pulse.
- rdata  out  32  extended load result; valid while done=1 and held until the next load completes.
- err  out  1  misalignment flag, valid with done (see Configuration).
- MemAddr  out  32  registered word address {addr[31:2],2'b00}.
- MemWr  out  1  registered memory write enable.
- MemDataIn  out  32  registered data to memory.
- MemDataOut  in  32  read data from memory.

## Operation

- States: IDLE, RD, WR, DONE.
- IDLE, req=1: latch we/size/sign_ext/addr[1:0]/wdata and register MemAddr.
  - Load or sub-word store: go to RD.
  - Word store: go to WR.
- RD: counter runs MEM_LAT+1 cycles. On the last cycle, capture MemDataOut into an internal word register.
  - Load: go to DONE.
  - Sub-word store: go to WR.
- WR: MemWr=1 for exactly one cycle.
  - MemDataIn = wdata for a word store.
  - For sub-word stores, MemDataIn = captured word with the addressed lane replaced.
  - Then go to DONE.
- DONE: done=1 for one cycle, then IDLE. req is ignored in RD/WR/DONE.
- Lanes are little-endian:
  - Byte lane k = addr[1:0] occupies bits [8k+7:8k].
  - Halfword lane addr[1] occupies [15:0] or [31:16]; addr[0] is ignored unless checking is enabled.
- Load result: extract the lane, then sign-extend or zero-extend to 32 bits. Word loads pass through unchanged.
- Reset values: busy=0, done=0, rdata=0, err=0, MemAddr=0, MemWr=0, MemDataIn=0, state IDLE, counter 0.
- Reset mid-operation aborts immediately: MemWr=0 from the next cycle, no done pulse, and a partially merged store is never written.

## Timing

- Let E0 be the edge where req is sampled in IDLE.
- Load: done is high in the cycle after edge E0+MEM_LAT+1. rdata updates on that same edge. Latency is MEM_LAT+2 cycles (3 for MEM_LAT=1).
- Word store: MemWr is high in the cycle after E0. done is high in the cycle after E0+1. Latency is 2 cycles.
- Sub-word store: MemWr is high in the cycle after E0+MEM_LAT+1. done is high one cycle later. Latency is MEM_LAT+3 cycles.
- MemAddr stays stable from E0 until the DONE→IDLE edge.
- Back-to-back: a req held high through DONE is accepted on the first IDLE edge, so there is at least one idle cycle between transactions.
- Simultaneous reset and req: reset wins and the request is dropped.

## Configuration

- MEM_ALIGN_CHK_EN defined:
  - A halfword with addr[0]=1, or a word with addr[1:0]≠0, goes IDLE→DONE directly.
  - In that case there is no memory access: MemWr stays 0, rdata is unchanged, and done=1 with err=1 one cycle after E0.
- MEM_ALIGN_CHK_EN undefined:
  - Low address bits below the access size are ignored (forced aligned).
  - err is tied to 0.

## Test plan

- Reset held 2 cycles mid load → all outputs 0, state IDLE, no done; next req proceeds normally.
- Word load, addr=0x10, mem[0x10]=0xDEADBEEF, MEM_LAT=1 → MemAddr=0x10, done in the 3rd cycle after E0, rdata=0xDEADBEEF.
- Byte load addr=0x13, mem=0x80FF7F01: sign_ext=1 → rdata=0xFFFFFF80; sign_ext=0 → 0x00000080. Halfword load addr=0x12 sign_ext=1 → 0xFFFF80FF.
- Byte store addr=0x21, wdata=0x000000AB, mem[0x20]=0x11223344 → exactly one MemWr pulse with MemDataIn=0x1122AB44; subsequent word load returns 0x1122AB44.
- Word store addr=0x30, wdata=0xCAFEF00D → MemWr high in the cycle after E0, done in the cycle after E0+1; req pulsed while busy produces no second MemWr.
- MEM_ALIGN_CHK_EN defined: halfword store addr=0x41 → done=1 and err=1 in the cycle after E0, MemWr never asserted. Undefined: same request writes lane [15:0] of word 0x40, err=0.
